// File: rtl/stack_reverser_if.sv
// Push/pop port between the reverser (master) and a LIFO stack (slave).
// rdata is returned by the stack one cycle after pop.
interface stack_reverser_if #(
    parameter int DATA_W = 8
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output push, output pop, output wdata, input rdata);
    modport slave  (input push, input pop, input wdata, output rdata);
endinterface

// File: rtl/stack_reverser.sv
// Byte-stream reverser: fills an external LIFO with a frame, then pops it back out in reverse.
// Optional sticky truncation flag on ovf is built when STACK_REVERSER_OVF_EN is defined.
//
// state | meaning
// FILL  | accept input bytes, push each into the stack
// POP   | single-cycle pop strobe
// CAP   | capture popped stack data into the output register
// OUT   | present reversed byte until downstream accepts it
module stack_reverser #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    stack_reverser_if.master  stk,
    output logic              busy,
    output logic              ovf
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, POP, CAP, OUT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            last_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        stk.push  = 1'b0;
        stk.pop   = 1'b0;
        stk.wdata = in_data;
        case (state)
            FILL: begin
                in_ready = (count < CNT_MAX);
                if (in_valid && in_ready) begin
                    stk.push = 1'b1;
                    // A full stack terminates the frame even without in_last
                    if (in_last || (count == CNT_LAST)) begin
                        state_nxt = POP;
                    end
                end
            end
            POP: begin
                stk.pop   = 1'b1;
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    state_nxt = (count != '0) ? POP : FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            last_pend <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (stk.push) begin
                count <= count + 1'b1;
            end else if (stk.pop) begin
                count <= count - 1'b1;
            end
            if (state == POP) begin
                last_pend <= (count == CW'(1));
            end
            if (state == CAP) begin
                out_data  <= stk.rdata;
                out_valid <= 1'b1;
                out_last  <= last_pend;
            end else if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != FILL) || (count != '0);

`ifdef STACK_REVERSER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (stk.push && !in_last && (count == CNT_LAST)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_reverser.sv
// Directed bench for stack_reverser with a behavioural LIFO on the stack port.
// Expected ovf follows STACK_REVERSER_OVF_EN.
module tb_stack_reverser;
    localparam int DEPTH = 16;
`ifdef STACK_REVERSER_OVF_EN
    localparam bit EXP_OVF = 1'b1;
`else
    localparam bit EXP_OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       ovf;

    stack_reverser_if #(.DATA_W(8)) stk_bus ();

    stack_reverser #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .stk       (stk_bus.master),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural LIFO sharing the reset net; also flags protocol violations
    logic [7:0] mem [DEPTH];
    int sp = 0;
    int proto_err = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp = 0;
            stk_bus.rdata <= 8'h00;
        end else begin
            if (stk_bus.push && stk_bus.pop) proto_err++;
            if (stk_bus.pop && sp == 0) proto_err++;
            if (stk_bus.push && sp == DEPTH) proto_err++;
            if (stk_bus.push && sp < DEPTH) begin
                mem[sp] = stk_bus.wdata;
                sp++;
                push_cnt++;
            end else if (stk_bus.pop && sp > 0) begin
                sp--;
                stk_bus.rdata <= mem[sp];
                pop_cnt++;
            end
        end
    end

    logic [7:0] fb[$];
    logic [7:0] gd[$];
    bit         gl[$];
    int         acc_cyc, lat, min_gap, max_gap, unstable, tmo;
    bit         rdy_post, rdy_after;

    task automatic feed(input bit last_final);
        int w;
        tmo = 0;
        foreach (fb[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fb[i];
            in_last  = last_final && (i == fb.size() - 1);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) tmo = 1;
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rdy_post = in_ready;
    endtask

    // rmode 0: out_ready held high; rmode 1: out_ready toggles every cycle
    task automatic run_frame(input bit last_final, input int rmode);
        int   prev_cyc;
        bit   prev_hold;
        logic [7:0] prev_d;
        logic prev_l;
        gd.delete();
        gl.delete();
        lat = -1; min_gap = 1000; max_gap = 0; unstable = 0;
        prev_cyc = 0; prev_hold = 0; prev_d = 8'h00; prev_l = 1'b0;
        feed(last_final);
        for (int n = 0; n < 400 && gd.size() < fb.size(); n++) begin
            if (n > 0) @(negedge clk);
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (prev_hold && (!out_valid || out_data !== prev_d || out_last !== prev_l)) unstable++;
            prev_hold = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            if (out_valid && out_ready) begin
                if (gd.size() == 0) begin
                    lat = cyc - acc_cyc;
                end else begin
                    if (cyc - prev_cyc < min_gap) min_gap = cyc - prev_cyc;
                    if (cyc - prev_cyc > max_gap) max_gap = cyc - prev_cyc;
                end
                prev_cyc = cyc;
                gd.push_back(out_data);
                gl.push_back(out_last);
            end
        end
        if (gd.size() < fb.size()) tmo = 1;
        @(negedge clk);
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, stk_bus.push, stk_bus.pop, busy, ovf, out_data} !== {7'b1000000, 8'h00}) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", {in_ready, out_valid, out_last, stk_bus.push, stk_bus.pop, busy, ovf, out_data}, {7'b1000000, 8'h00});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] exp_d [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        bit         exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        fb = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(1'b1, 0);
        checks++;
        if (tmo !== 0 || gd.size() !== 4) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=4 timeout=%0d", gd.size(), tmo);
        end
        for (int i = 0; i < 4 && i < gd.size(); i++) begin
            checks++;
            if (gd[i] !== exp_d[i] || gl[i] !== exp_l[i]) begin
                failures++;
                $display("FAIL basic_byte[%0d] got=%h/%0d exp=%h/%0d", i, gd[i], gl[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=3", lat);
        end
        checks++;
        if (min_gap !== 3 || max_gap !== 3) begin
            failures++;
            $display("FAIL basic_throughput got=%0d..%0d exp=3", min_gap, max_gap);
        end
        checks++;
        if (rdy_after !== 1'b1 || rdy_post !== 1'b0) begin
            failures++;
            $display("FAIL basic_in_ready got=%0d/%0d exp=0/1", rdy_post, rdy_after);
        end
    endtask

    task automatic test_toggle;
        logic [7:0] exp_d [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        int p0;
        p0 = pop_cnt;
        fb = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(1'b1, 1);
        checks++;
        if (tmo !== 0 || gd.size() !== 4) begin
            failures++;
            $display("FAIL toggle_count got=%0d exp=4 timeout=%0d", gd.size(), tmo);
        end
        for (int i = 0; i < 4 && i < gd.size(); i++) begin
            checks++;
            if (gd[i] !== exp_d[i] || gl[i] !== (i == 3)) begin
                failures++;
                $display("FAIL toggle_byte[%0d] got=%h/%0d exp=%h/%0d", i, gd[i], gl[i], exp_d[i], (i == 3));
            end
        end
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL toggle_stable got=%0d unstable_cycles exp=0", unstable);
        end
        checks++;
        if (pop_cnt - p0 !== 4) begin
            failures++;
            $display("FAIL toggle_pops got=%0d exp=4", pop_cnt - p0);
        end
    endtask

    task automatic test_single;
        int p0, q0;
        p0 = push_cnt;
        q0 = pop_cnt;
        fb = '{8'hA5};
        run_frame(1'b1, 0);
        checks++;
        if (tmo !== 0 || gd.size() !== 1 || gd[0] !== 8'hA5 || gl[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_byte got_n=%0d data=%h last=%0d exp_n=1 data=a5 last=1", gd.size(), gd.size() > 0 ? gd[0] : 8'hxx, gl.size() > 0 ? gl[0] : 1'b0);
        end
        checks++;
        if (push_cnt - p0 !== 1 || pop_cnt - q0 !== 1) begin
            failures++;
            $display("FAIL single_strobes got push=%0d pop=%0d exp=1/1", push_cnt - p0, pop_cnt - q0);
        end
    endtask

    task automatic test_full_last;
        fb.delete();
        for (int i = 0; i < DEPTH; i++) fb.push_back(8'(i + 8'h20));
        run_frame(1'b1, 0);
        checks++;
        if (tmo !== 0 || gd.size() !== DEPTH || gd[0] !== 8'h2F || gd[DEPTH-1] !== 8'h20 || gl[DEPTH-1] !== 1'b1 || gl[0] !== 1'b0) begin
            failures++;
            $display("FAIL full_last_frame got_n=%0d timeout=%0d exp_n=16 first=2f final=20 with last", gd.size(), tmo);
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_last_ovf got=%0d exp=0", ovf);
        end
    endtask

    task automatic test_full;
        fb.delete();
        for (int i = 0; i < DEPTH; i++) fb.push_back(8'(i));
        run_frame(1'b0, 0);
        checks++;
        if (rdy_post !== 1'b0 || tmo !== 0 || gd.size() !== DEPTH) begin
            failures++;
            $display("FAIL full_accept got in_ready=%0d n=%0d timeout=%0d exp in_ready=0 n=16", rdy_post, gd.size(), tmo);
        end
        for (int i = 0; i < DEPTH && i < gd.size(); i++) begin
            checks++;
            if (gd[i] !== 8'(15 - i) || gl[i] !== (i == DEPTH - 1)) begin
                failures++;
                $display("FAIL full_byte[%0d] got=%h/%0d exp=%h/%0d", i, gd[i], gl[i], 8'(15 - i), (i == DEPTH - 1));
            end
        end
        checks++;
        if (ovf !== EXP_OVF || rdy_after !== 1'b1) begin
            failures++;
            $display("FAIL full_ovf got ovf=%0d in_ready=%0d exp ovf=%0d in_ready=1", ovf, rdy_after, EXP_OVF);
        end
    endtask

    task automatic test_reset_mid;
        int  hs;
        bit  found;
        hs = 0;
        found = 0;
        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        feed(1'b1);
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) begin
                if (hs == 1) begin
                    found = 1;
                    break;
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++;
        if (!found || out_data !== 8'h04) begin
            failures++;
            $display("FAIL mid_second_out got found=%0d data=%h exp found=1 data=04", found, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, stk_bus.push, stk_bus.pop, busy, ovf, out_data} !== {7'b1000000, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset_values got=%b exp=%b", {in_ready, out_valid, out_last, stk_bus.push, stk_bus.pop, busy, ovf, out_data}, {7'b1000000, 8'h00});
        end
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b1;
        fb = '{8'h10, 8'h20};
        run_frame(1'b1, 0);
        checks++;
        if (tmo !== 0 || gd.size() !== 2 || gd[0] !== 8'h20 || gd[1] !== 8'h10 || gl[0] !== 1'b0 || gl[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_next_frame got_n=%0d first=%h second=%h exp_n=2 20 then 10(last)", gd.size(), gd.size() > 0 ? gd[0] : 8'hxx, gd.size() > 1 ? gd[1] : 8'hxx);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (proto_err !== 0) begin
            failures++;
            $display("FAIL protocol_violations got=%0d exp=0", proto_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_toggle;
        test_single;
        test_full_last;
        test_full;
        test_reset_mid;
        test_protocol;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_reverser.md
# stack_reverser

Byte-stream reverser that drives a LIFO stack through its push/pop port. It accepts a frame on a valid/ready input, pushes each byte into the stack, then pops the bytes back out and emits them in reverse order on a valid/ready output. It sits on the master side of the stack interface: it generates every push and pop, and it consumes the stack's read data. It never lets the stack overflow or underflow.

## Interface
Parameters:
- DATA_W, 8, byte width of stream and stack data
- DEPTH, 16, stack capacity in entries; maximum frame length

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_ready  out  1  block accepts byte this cycle
- in_data  in  DATA_W  upstream byte
- in_last  in  1  marks final byte of frame (qualified by in_valid)
- out_valid  out  1  reversed byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  DATA_W  reversed byte
- out_last  out  1  marks final reversed byte (the first byte received)
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_wdata  out  DATA_W  data pushed
- stk_rdata  in  DATA_W  data popped, valid one cycle after stk_pop
- busy  out  1  high in any state other than FILL, or when count ≠ 0
- ovf  out  1  sticky frame-truncated flag (see Configuration)

## Operation
- The internal occupancy counter `count` is $clog2(DEPTH+1) bits wide. It increments on push, decrements on pop, and never wraps.
- FSM states: FILL, POP, CAP, OUT.
- FILL:
  - in_ready = (count < DEPTH).
  - On in_valid & in_ready: stk_push = 1 (combinational) and stk_wdata = in_data. count then increments.
  - If that byte has in_last = 1, or count+1 == DEPTH, go to POP next cycle.
- POP: stk_pop = 1 for exactly one cycle. count decrements. Set the internal flag last_pend = (count == 1). Go to CAP.
- CAP: out_data <= stk_rdata, out_valid <= 1, out_last <= last_pend. Go to OUT.
- OUT:
  - Hold out_data, out_valid and out_last stable until out_ready.
  - On out_valid & out_ready, clear out_valid. Go to POP if count > 0, else to FILL.
- stk_push and stk_pop are never high in the same cycle.
- stk_pop is never issued with count == 0.
- stk_push is never issued with count == DEPTH.
- in_ready is 0 in POP, CAP and OUT. Input is back-pressured for the whole drain.
- Frame reaches DEPTH without in_last: the frame is drained as if terminated, and out_last is asserted on the last popped byte. The next input byte starts a new frame.
- in_valid without in_last never starts a drain by itself. A partial frame waits in FILL indefinitely.

## Timing
- Reset values: state = FILL, count = 0, in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, stk_push = 0, stk_pop = 0, busy = 0, ovf = 0.
- Reset mid-operation: all registers return to reset values immediately. The attached stack must be reset by the same reset net, inverted to the stack's polarity.
- Latency from accepting in_last to the first out_valid: 3 cycles (FILL→POP→CAP→OUT, out_valid high in the first OUT cycle).
- Drain throughput: one byte per 3 cycles with out_ready held high. Each extra cycle of out_ready low adds 1 cycle.
- After the final out handshake, in_ready goes high on the next cycle.
- stk_rdata is sampled only in CAP. Its value is a don't-care at all other times.

## Configuration
- Macro: STACK_REVERSER_OVF_EN.
- Defined:
  - ovf is set to 1 when a frame reaches DEPTH bytes and the DEPTH-th byte has in_last = 0.
  - ovf stays set until rst_n is asserted.
  - A frame of exactly DEPTH bytes with in_last on the final byte does not set ovf.
- Undefined:
  - ovf is tied to 0 and no detection logic is built.
  - Truncation behaviour in Operation is unchanged.

## Test plan
- Frame of 4 bytes, 0x11, 0x22, 0x33, 0x44, with in_last on 0x44 and out_ready held at 1 -> out bytes 0x44, 0x33, 0x22, 0x11 with out_last only on 0x11. First out_valid appears 3 cycles after 0x44 is accepted. in_ready returns 1 the cycle after 0x11 is accepted.
- Same frame with out_ready toggled 1/0 each cycle -> identical byte order. out_data is stable while out_valid & !out_ready. No extra stk_pop is issued.
- DEPTH = 16 bytes, 0x00–0x0F, with no in_last -> in_ready drops after the 16th byte. Output is 0x0F down to 0x00 with out_last on 0x00. ovf = 1 with STACK_REVERSER_OVF_EN defined, ovf = 0 without it.
- Single-byte frame 0xA5 with in_last -> exactly one output, 0xA5 with out_last = 1. stk_push count = 1 and stk_pop count = 1.
- Frame 0x01–0x05 with rst_n pulsed low during the second OUT -> all outputs are at reset values during reset. A following frame 0x10, 0x20 (last) yields 0x20, 0x10 with no stale bytes.
- Continuous checker over all scenarios -> stk_push & stk_pop never both high. No pop when count = 0. No push when count = DEPTH.
